hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-load hazard detect unit.
- Tracks pending register writes with per-register latency countdowns, so multi-cycle producers (loads, multi-cycle ALU ops) stall dependents for exactly the required cycles.
- Adds a halt drain state machine, a branch-flush interaction and a global memory-stall freeze.
- Sits between IF/ID and ID/EX; drives the PC write enable, the IF/ID write enable and the ID/EX bubble.

Parameters:
- NUM_REGS, 16, architectural register count; register 0 is hardwired zero and never tracked.
- REG_AW, 4, register index width (log2 NUM_REGS).
- OPC_W, 4, opcode width.
- HLT_OPC, 4'hF, halt opcode value.
- LAT_W, 2, width of latency code and of each scoreboard counter.
- DRAIN_CYC, 3, cycles after the scoreboard empties before halted asserts (EX/MEM/WB retire).

Ports:
- clk input 1 system clock
- rst input 1 synchronous active-high reset
- opcode input OPC_W opcode of instruction in ID
- if_id_rs input REG_AW source register 1 in ID
- if_id_rt input REG_AW source register 2 in ID
- rs_vld input 1 ID instruction reads rs
- rt_vld input 1 ID instruction reads rt
- wr_en input 1 ID instruction writes a register
- wr_rd input REG_AW destination register of ID instruction
- wr_lat input LAT_W cycles until the result is forwardable (0 = forwardable next cycle)
- mem_stall input 1 memory not ready; whole pipeline frozen
- flush input 1 taken branch; ID instruction is killed
- pc_write output 1 PC update enable
- if_id_write output 1 IF/ID register write enable
- id_ex_bubble output 1 insert NOP into ID/EX
- stall output 1 any stall condition
- halted output 1 sticky; pipeline fully drained after HLT

Behaviour:
- Scoreboard: cnt[r], LAT_W bits, r = 1..NUM_REGS-1. Reset: all 0.
- hazard = (rs_vld & cnt[if_id_rs]!=0) | (rt_vld & cnt[if_id_rt]!=0); register 0 never hazards.
- issue = ~stall & ~flush & wr_en & wr_rd!=0 & state==RUN & opcode!=HLT_OPC.
- Each clock, if ~mem_stall: nonzero counters decrement by 1. If issue: cnt[wr_rd] <= wr_lat, overriding the decrement (the younger producer wins).
- If mem_stall: counters hold; issue is suppressed.
- FSM states RUN, DRAIN, HALTED; reset state RUN.
- RUN -> DRAIN when opcode==HLT_OPC, ~hazard, ~flush and ~mem_stall. HLT itself never enters EX.
- DRAIN: all counters zero and ~mem_stall -> load drain counter with DRAIN_CYC; decrement each ~mem_stall cycle; at 0 -> HALTED.
- flush in DRAIN -> RUN (the HLT was on the wrong path); the drain counter clears.
- HALTED: held until rst; halted=1.
- stall = mem_stall | (state==RUN & hazard & ~flush) | (state==RUN & opcode==HLT_OPC & ~flush) | state!=RUN.
- pc_write = ~stall; if_id_write = ~stall. flush with ~mem_stall forces both to 1.
- id_ex_bubble = ~mem_stall & (flush | hazard | opcode==HLT_OPC | state!=RUN).
- During mem_stall, id_ex_bubble=0 (freeze, not bubble).
- Outputs are combinational from registered state plus current inputs; latency 0.
- Reset values: pc_write=1, if_id_write=1, id_ex_bubble=0, stall=0, halted=0 (with inputs idle).
- Reset mid-DRAIN or in HALTED returns to RUN with the scoreboard cleared on the next edge.
- Simultaneous flush and hazard: flush wins; no stall, bubble asserted.

Optional Feature:
- Macro HAZARD_SCOREBOARD_PERF_EN.
- When defined: adds output stall_cycles[15:0], which counts cycles with stall=1 and saturates at 16'hFFFF. Reset value 0.
- When undefined: no port and no counter logic.

Test Plan:
- Load r3 (wr_lat=1), next instruction reads rs=3 -> exactly 1 cycle with stall=1, id_ex_bubble=1, pc_write=0; then issue proceeds.
- wr_lat=3 to r5, then 1 independent instruction, then reader of r5 -> reader stalls 2 cycles.
- Reader of r5 while cnt[5]=2 and mem_stall=1 for 4 cycles -> counter holds at 2, id_ex_bubble=0 during the freeze; 2 stall cycles after mem_stall drops.
- HLT in ID with cnt[7]=2 -> DRAIN; halted rises 2+DRAIN_CYC=5 cycles later and stays 1; pc_write stays 0.
- HLT in ID, flush on the next cycle -> returns to RUN, pc_write=1, halted stays 0.
- Reads of register 0 with wr_rd=0, wr_lat=3 issued earlier -> no stall. With the macro defined, after case 1: stall_cycles=1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard hazard unit with halt drain, branch flush and memory-stall freeze.
// Optional stall-cycle counter port: define HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
   parameter int               NUM_REGS  = 16,
   parameter int               REG_AW    = 4,
   parameter int               OPC_W     = 4,
   parameter logic [OPC_W-1:0] HLT_OPC   = 4'hF,
   parameter int               LAT_W     = 2,
   parameter int               DRAIN_CYC = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [REG_AW-1:0] if_id_rs,
   input  logic [REG_AW-1:0] if_id_rt,
   input  logic              rs_vld,
   input  logic              rt_vld,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_rd,
   input  logic [LAT_W-1:0]  wr_lat,
   input  logic              mem_stall,
   input  logic              flush,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              id_ex_bubble,
   output logic              stall,
   output logic              halted
`ifdef HAZARD_SCOREBOARD_PERF_EN
   ,output logic [15:0]      stall_cycles
`endif
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;
   localparam int         DW        = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

   logic [LAT_W-1:0] cnt [NUM_REGS];
   logic [1:0]       state;
   logic [DW-1:0]    drain_cnt;
   logic             drain_armed;
   logic [DW-1:0]    drain_left;
   logic             run;
   logic             is_hlt;
   logic             hazard;
   logic             sb_empty;
   logic             issue;

   assign run    = (state == ST_RUN);
   assign is_hlt = (opcode == HLT_OPC);
   assign hazard = (rs_vld && (if_id_rs != '0) && (cnt[if_id_rs] != '0)) ||
                   (rt_vld && (if_id_rt != '0) && (cnt[if_id_rt] != '0));

   always_comb begin
      sb_empty = 1'b1;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (cnt[r] != '0) sb_empty = 1'b0;
      end
   end

   assign stall        = mem_stall | (run & hazard & ~flush) | (run & is_hlt & ~flush) | ~run;
   assign pc_write     = ~stall | (flush & ~mem_stall);
   assign if_id_write  = ~stall | (flush & ~mem_stall);
   assign id_ex_bubble = ~mem_stall & (flush | hazard | is_hlt | ~run);
   assign halted       = (state == ST_HALTED);
   assign issue        = ~stall & ~flush & wr_en & (wr_rd != '0) & run & ~is_hlt;

   // A fresh issue overrides the decrement so the younger producer's latency wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      end else if (!mem_stall) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (issue && (wr_rd == REG_AW'(r)))
               cnt[r] <= wr_lat;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - LAT_W'(1);
         end
      end
   end

   // The first empty cycle in DRAIN counts as the first of the DRAIN_CYC retire cycles.
   assign drain_left = drain_armed ? drain_cnt : DW'(DRAIN_CYC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         drain_cnt   <= '0;
         drain_armed <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (is_hlt && !hazard && !flush && !mem_stall) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (flush) begin
                  state       <= ST_RUN;
                  drain_cnt   <= '0;
                  drain_armed <= 1'b0;
               end else if (sb_empty && !mem_stall) begin
                  if (drain_left <= DW'(1)) begin
                     state       <= ST_HALTED;
                     drain_cnt   <= '0;
                     drain_armed <= 1'b0;
                  end else begin
                     drain_cnt   <= drain_left - DW'(1);
                     drain_armed <= 1'b1;
                  end
               end
            end
            ST_HALTED: state <= ST_HALTED;
            default:   state <= ST_RUN;
         endcase
      end
   end

`ifdef HAZARD_SCOREBOARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= '0;
      else if (stall && (stall_cycles != 16'hFFFF))
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] opcode, if_id_rs, if_id_rt, wr_rd;
   logic       rs_vld, rt_vld, wr_en, mem_stall, flush;
   logic [1:0] wr_lat;
   logic       pc_write, if_id_write, id_ex_bubble, stall, halted;
`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [15:0] stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   // Model: remaining cycles per register, mode 0=run 1=drain 2=halted, empty cycles seen while draining.
   int       m_pend [16];
   int       m_mode;
   int       m_empties;
   int       m_perf;
   bit       m_hz;
   bit       e_stall;
   bit       e_issue;
   logic [4:0] e_vec;
   wire  [4:0] obs = {stall, pc_write, if_id_write, id_ex_bubble, halted};

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk(clk), .rst(rst), .opcode(opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
      .rs_vld(rs_vld), .rt_vld(rt_vld), .wr_en(wr_en), .wr_rd(wr_rd), .wr_lat(wr_lat),
      .mem_stall(mem_stall), .flush(flush), .pc_write(pc_write), .if_id_write(if_id_write),
      .id_ex_bubble(id_ex_bubble), .stall(stall), .halted(halted)
`ifdef HAZARD_SCOREBOARD_PERF_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   task automatic model_eval();
      bit hlt, run, pcw, bub;
      hlt  = (opcode == 4'hF);
      run  = (m_mode == 0);
      m_hz = (rs_vld && if_id_rs != 0 && m_pend[if_id_rs] > 0) ||
             (rt_vld && if_id_rt != 0 && m_pend[if_id_rt] > 0);
      e_stall = mem_stall || (run && m_hz && !flush) || (run && hlt && !flush) || !run;
      pcw     = !e_stall || (flush && !mem_stall);
      bub     = !mem_stall && (flush || m_hz || hlt || !run);
      e_issue = !e_stall && !flush && wr_en && wr_rd != 0 && run && !hlt;
      e_vec   = {e_stall, pcw, pcw, bub, (m_mode == 2)};
   endtask

   task automatic model_commit();
      bit empty;
      model_eval();
      if (rst) begin
         for (int r = 0; r < 16; r++) m_pend[r] = 0;
         m_mode = 0; m_empties = 0; m_perf = 0;
         return;
      end
      empty = 1'b1;
      for (int r = 1; r < 16; r++) if (m_pend[r] > 0) empty = 1'b0;
      if (e_stall && m_perf < 65535) m_perf++;
      if (!mem_stall) begin
         for (int r = 1; r < 16; r++) if (m_pend[r] > 0) m_pend[r]--;
         if (e_issue) m_pend[wr_rd] = int'(wr_lat);
      end
      if (m_mode == 0) begin
         if (opcode == 4'hF && !m_hz && !flush && !mem_stall) begin
            m_mode = 1; m_empties = 0;
         end
      end else if (m_mode == 1) begin
         if (flush) m_mode = 0;
         else if (empty && !mem_stall) begin
            m_empties++;
            if (m_empties == 3) m_mode = 2;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] rs, input logic rsv,
                        input logic [3:0] rt, input logic rtv, input logic we,
                        input logic [3:0] rd, input logic [1:0] lat, input logic ms, input logic fl);
      opcode = op; if_id_rs = rs; rs_vld = rsv; if_id_rt = rt; rt_vld = rtv;
      wr_en = we; wr_rd = rd; wr_lat = lat; mem_stall = ms; flush = fl;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1 model_eval();
      checks++;
      if (obs !== 5'b01100) begin
         errors++; $display("FAIL reset_outputs: got %b want %b", obs, 5'b01100);
      end
      checks++;
      if (obs !== e_vec) begin
         errors++; $display("FAIL reset_model: got %b want %b", obs, e_vec);
      end
`ifdef HAZARD_SCOREBOARD_PERF_EN
      checks++;
      if (stall_cycles !== 16'd0) begin
         errors++; $display("FAIL reset_perf: got %0d want 0", stall_cycles);
      end
`endif
   endtask

   task automatic test_load_use();
      int n = 0;
      bit done;
      drive(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd3, 2'd1, 1'b0, 1'b0);
      #1 model_eval();
      checks++;
      if (obs !== e_vec) begin errors++; $display("FAIL load_issue: got %b want %b", obs, e_vec); end
      tick();
      drive(4'h2, 4'd3, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         #1 model_eval();
         checks++;
         if (obs !== e_vec) begin errors++; $display("FAIL load_use_cyc%0d: got %b want %b", i, obs, e_vec); end
         if (stall) n++;
         done = !stall;
         tick();
         if (done) break;
      end
      checks++;
      if (n != 1) begin errors++; $display("FAIL load_use_stalls: got %0d want 1", n); end
`ifdef HAZARD_SCOREBOARD_PERF_EN
      checks++;
      if (stall_cycles !== 16'd1) begin errors++; $display("FAIL load_use_perf: got %0d want 1", stall_cycles); end
`endif
   endtask

   task automatic test_multi_lat(input bit freeze);
      int n = 0;
      bit done;
      apply_reset();
      drive(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd5, 2'd3, 1'b0, 1'b0);
      tick();
      drive(4'h2, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd6, 2'd0, 1'b0, 1'b0);
      #1 model_eval();
      checks++;
      if (obs !== e_vec) begin errors++; $display("FAIL multi_indep: got %b want %b", obs, e_vec); end
      tick();
      drive(4'h3, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'h0, 2'd0, freeze, 1'b0);
      if (freeze) begin
         for (int i = 0; i < 4; i++) begin
            #1 model_eval();
            checks++;
            if (obs !== e_vec || id_ex_bubble !== 1'b0 || stall !== 1'b1 || pc_write !== 1'b0) begin
               errors++; $display("FAIL freeze_cyc%0d: got %b want %b", i, obs, e_vec);
            end
            tick();
         end
         mem_stall = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         #1 model_eval();
         checks++;
         if (obs !== e_vec) begin errors++; $display("FAIL multi_cyc%0d: got %b want %b", i, obs, e_vec); end
         if (stall) n++;
         done = !stall;
         tick();
         if (done) break;
      end
      checks++;
      if (n != 2) begin errors++; $display("FAIL multi_stalls(freeze=%0d): got %0d want 2", freeze, n); end
   endtask

   task automatic test_halt_drain();
      int k = -1;
      int bad_pcw = 0;
      int lost = 0;
      apply_reset();
      drive(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd7, 2'd2, 1'b0, 1'b0);
      tick();
      drive(4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         #1 model_eval();
         checks++;
         if (obs !== e_vec) begin errors++; $display("FAIL halt_cyc%0d: got %b want %b", i, obs, e_vec); end
         if (pc_write !== 1'b0) bad_pcw++;
         if (halted === 1'b1 && k < 0) k = i;
         if (k >= 0 && halted !== 1'b1) lost++;
         tick();
      end
      checks++;
      if (k != 5) begin errors++; $display("FAIL halt_latency: got %0d want 5", k); end
      checks++;
      if (bad_pcw != 0 || lost != 0) begin
         errors++; $display("FAIL halt_sticky: pc_write high %0d cycles, halted dropped %0d cycles, want 0/0", bad_pcw, lost);
      end
   endtask

   task automatic test_halt_flush();
      apply_reset();
      drive(4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
      tick();
      drive(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
      #1 model_eval();
      checks++;
      if (obs !== e_vec || pc_write !== 1'b1 || halted !== 1'b0) begin
         errors++; $display("FAIL halt_flush: got %b want %b", obs, e_vec);
      end
      tick();
      flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1 model_eval();
         checks++;
         if (obs !== 5'b01100) begin errors++; $display("FAIL halt_flush_run%0d: got %b want %b", i, obs, 5'b01100); end
         tick();
      end
   endtask

   task automatic test_reg0_and_flush();
      apply_reset();
      drive(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 2'd3, 1'b0, 1'b0);
      tick();
      drive(4'h2, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
      #1 model_eval();
      checks++;
      if (obs !== 5'b01100) begin errors++; $display("FAIL reg0_read: got %b want %b", obs, 5'b01100); end
      tick();
      drive(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd2, 2'd2, 1'b0, 1'b0);
      tick();
      drive(4'h2, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
      #1 model_eval();
      checks++;
      if (obs !== 5'b01110) begin errors++; $display("FAIL flush_beats_hazard: got %b want %b", obs, 5'b01110); end
      tick();
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
         #1 model_eval();
         checks++;
         if (obs !== e_vec) begin errors++; $display("FAIL random_cyc%0d: got %b want %b", i, obs, e_vec); end
`ifdef HAZARD_SCOREBOARD_PERF_EN
         checks++;
         if (stall_cycles !== 16'(m_perf)) begin
            errors++; $display("FAIL random_perf%0d: got %0d want %0d", i, stall_cycles, m_perf);
         end
`endif
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int r = 0; r < 16; r++) m_pend[r] = 0;
      m_mode = 0; m_empties = 0; m_perf = 0;
      rst = 1'b1;
      drive(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      test_reset();
      test_load_use();
      test_multi_lat(1'b0);
      test_multi_lat(1'b1);
      test_halt_drain();
      test_halt_flush();
      test_reg0_and_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
